cva6_axi_sram_slave: RTL and testbench

AXI4 responder (slave) backed by an on-chip word array. Sits at the far end of the flattened AXI master port that leaves the CVA6 core wrapper, downstream of the atomics adapter. Used as a boot/scratch memory in core-level benches and small SoC configs. Independent read and write channel FSMs share one 1R1W storage array; supports FIXED, INCR and WRAP bursts.

---
 rtl/cva6_axi_sram_pkg.sv | 32 +++
 rtl/cva6_axi_sram_burst_ctr.sv | 73 +++++++
 rtl/cva6_axi_sram.sv | 221 ++++++++++++++++++++++
 tb/tb_cva6_axi_sram_slave.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_axi_sram_pkg.sv
// Shared types, response codes and burst address arithmetic for the AXI SRAM responder.
package cva6_axi_sram_pkg;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address of the beat following addr; reserved burst encodings advance like INCR.
  function automatic logic [63:0] next_addr(input logic [63:0]       addr,
                                            input logic [SIZE_W-1:0] size,
                                            input logic [LEN_W-1:0]  len,
                                            input logic [1:0]        burst);
    logic [63:0] stride;
    logic [63:0] mask;
    stride = 64'd1 << size;
    mask   = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (addr & ~mask) | ((addr + stride) & mask);
      default: next_addr = addr + stride;
    endcase
  endfunction

endpackage

// File: rtl/cva6_axi_sram_burst_ctr.sv
// Per-channel burst tracker: latches the address phase, counts beats, advances the
// beat address and flags errored bursts.
// Ports: load_i/advance_i control; addr/len/size/burst/ext_err payload in;
//        idx_o word index of the current beat, last_o final beat, err_o SLVERR burst.
module cva6_axi_sram_burst_ctr
  import cva6_axi_sram_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 64,
  parameter int unsigned          MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(64'h8000_0000)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         load_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [LEN_W-1:0]             len_i,
  input  logic [SIZE_W-1:0]            size_i,
  input  logic [1:0]                   burst_i,
  input  logic                         ext_err_i,
  input  logic                         advance_i,
  output logic [$clog2(MEM_WORDS)-1:0] idx_o,
  output logic                         last_o,
  output logic                         err_o
);

  localparam int unsigned       IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LIMIT = BASE_ADDR + ADDR_W'(MEM_WORDS * 8);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [SIZE_W-1:0] size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic              range_err;
  logic              wrap_err;
  logic [ADDR_W-1:0] offset;
  logic              unused_offset;

  // Errors are judged once, on the address phase, and held for the whole burst.
  assign range_err = (addr_i < BASE_ADDR) || (addr_i >= LIMIT);
  assign wrap_err  = (burst_i == WRAP) &&
                     !((len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      len_q   <= len_i;
      cnt_q   <= '0;
      size_q  <= size_i;
      burst_q <= burst_i;
      err_q   <= ext_err_i | range_err | wrap_err | (size_i > 3'd3);
    end else if (advance_i) begin
      addr_q  <= ADDR_W'(next_addr(64'(addr_q), size_q, len_q, burst_q));
      cnt_q   <= cnt_q + 8'd1;
    end
  end

  // Word index keeps only the in-array bits of the byte offset.
  assign offset        = addr_q - BASE_ADDR;
  assign idx_o         = offset[IDX_W+2:3];
  assign unused_offset = ^{offset[ADDR_W-1:IDX_W+3], offset[2:0]};
  assign last_o        = (cnt_q == len_q);
  assign err_o         = err_q;

endmodule

// File: rtl/cva6_axi_sram.sv
// AXI4 responder backed by a 1R1W word array; independent write (AW/W/B) and read
// (AR/R) FSMs; FIXED, INCR and WRAP bursts.
// Ports: clk_i, rst_ni (async, active-low); AW/W/B write channels; AR/R read channels.
// Optional: define CVA6_AXI_SRAM_USER_ECHO_EN to echo aw_user_i/ar_user_i on B/R user.
module cva6_axi_sram_slave
  import cva6_axi_sram_pkg::*;
#(
  parameter int unsigned                    AXI_ADDRESS_WIDTH = 64,
  parameter int unsigned                    AXI_DATA_WIDTH    = 64,
  parameter int unsigned                    AXI_ID_WIDTH      = 4,
  parameter int unsigned                    AXI_USER_WIDTH    = 1,
  parameter int unsigned                    MEM_WORDS         = 1024,
  parameter logic [AXI_ADDRESS_WIDTH-1:0]   BASE_ADDR         = AXI_ADDRESS_WIDTH'(64'h8000_0000)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]        aw_id_i,
  input  logic [AXI_ADDRESS_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                     aw_len_i,
  input  logic [2:0]                     aw_size_i,
  input  logic [1:0]                     aw_burst_i,
  input  logic [5:0]                     aw_atop_i,
  input  logic [AXI_USER_WIDTH-1:0]      aw_user_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]      w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]    w_strb_i,
  input  logic                           w_last_i,
  input  logic [AXI_USER_WIDTH-1:0]      w_user_i,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]        b_id_o,
  output logic [1:0]                     b_resp_o,
  output logic [AXI_USER_WIDTH-1:0]      b_user_o,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]        ar_id_i,
  input  logic [AXI_ADDRESS_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                     ar_len_i,
  input  logic [2:0]                     ar_size_i,
  input  logic [1:0]                     ar_burst_i,
  input  logic [AXI_USER_WIDTH-1:0]      ar_user_i,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]        r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]      r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_last_o,
  output logic [AXI_USER_WIDTH-1:0]      r_user_o
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  if (AXI_DATA_WIDTH != 64) begin : g_dw_check
    $error("cva6_axi_sram_slave supports AXI_DATA_WIDTH = 64 only");
  end

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              aw_ready_d, w_ready_d, b_valid_d, ar_ready_d, r_valid_d;
  logic              wl_err_q, wl_err_d;
  logic [1:0]        b_resp_d;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [IDX_W-1:0]  wc_idx, rc_idx;
  logic              wc_last, rc_last, wc_err, rc_err;
  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i  & w_ready_o;
  assign b_hs  = b_valid_o  & b_ready_i;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o  & r_ready_i;

  cva6_axi_sram_burst_ctr #(
    .ADDR_W    (AXI_ADDRESS_WIDTH),
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_wr_ctr (
    .clk_i, .rst_ni,
    .load_i    (aw_hs),
    .addr_i    (aw_addr_i),
    .len_i     (aw_len_i),
    .size_i    (aw_size_i),
    .burst_i   (aw_burst_i),
    .ext_err_i (|aw_atop_i),
    .advance_i (w_hs),
    .idx_o     (wc_idx),
    .last_o    (wc_last),
    .err_o     (wc_err)
  );

  cva6_axi_sram_burst_ctr #(
    .ADDR_W    (AXI_ADDRESS_WIDTH),
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) u_rd_ctr (
    .clk_i, .rst_ni,
    .load_i    (ar_hs),
    .addr_i    (ar_addr_i),
    .len_i     (ar_len_i),
    .size_i    (ar_size_i),
    .burst_i   (ar_burst_i),
    .ext_err_i (1'b0),
    .advance_i (r_hs),
    .idx_o     (rc_idx),
    .last_o    (rc_last),
    .err_o     (rc_err)
  );

  // Write channel next state; handshake outputs are registered from the next state.
  always_comb begin
    w_state_d = w_state_q;
    wl_err_d  = wl_err_q;
    b_resp_d  = b_resp_o;
    unique case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_state_d = W_DATA;
        wl_err_d  = 1'b0;
      end
      W_DATA: if (w_hs) begin
        // A w_last_i disagreeing with the beat count only poisons the response.
        wl_err_d = wl_err_q | (w_last_i != wc_last);
        if (wc_last) begin
          w_state_d = W_RESP;
          b_resp_d  = (wc_err | wl_err_d) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
    w_ready_d  = (w_state_d == W_DATA);
    b_valid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      aw_ready_o <= 1'b0;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      wl_err_q   <= 1'b0;
      b_resp_o   <= RESP_OKAY;
      b_id_o     <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_o <= aw_ready_d;
      w_ready_o  <= w_ready_d;
      b_valid_o  <= b_valid_d;
      wl_err_q   <= wl_err_d;
      b_resp_o   <= b_resp_d;
      if (aw_hs) b_id_o <= aw_id_i;
    end
  end

  // Read channel next state; a beat stays presented until r_ready_i.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_BURST;
      R_BURST: if (r_hs && rc_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_BURST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      ar_ready_o <= 1'b0;
      r_valid_o  <= 1'b0;
      r_id_o     <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_ready_o <= ar_ready_d;
      r_valid_o  <= r_valid_d;
      if (ar_hs) r_id_o <= ar_id_i;
    end
  end

  // Byte-masked array write; errored bursts never touch the array.
  always_ff @(posedge clk_i) begin
    if (w_hs && !wc_err) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (w_strb_i[b]) mem[wc_idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  // Combinational read of the registered beat address gives read-old-data on collisions.
  assign r_data_o = (r_valid_o && !rc_err) ? mem[rc_idx] : '0;
  assign r_resp_o = (r_valid_o && rc_err) ? RESP_SLVERR : RESP_OKAY;
  assign r_last_o = r_valid_o & rc_last;

`ifdef CVA6_AXI_SRAM_USER_ECHO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_user_o <= '0;
      r_user_o <= '0;
    end else begin
      if (aw_hs) b_user_o <= aw_user_i;
      if (ar_hs) r_user_o <= ar_user_i;
    end
  end
  logic unused_user;
  assign unused_user = ^w_user_i;
`else
  assign b_user_o = '0;
  assign r_user_o = '0;
  logic unused_user;
  assign unused_user = ^{aw_user_i, ar_user_i, w_user_i};
`endif

endmodule

// File: tb/tb_cva6_axi_sram_slave.sv
// Directed self-checking bench for cva6_axi_sram_slave.
module tb_cva6_axi_sram_slave;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        aw_valid_i, aw_ready_o;
  logic [3:0]  aw_id_i;
  logic [63:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [2:0]  aw_size_i;
  logic [1:0]  aw_burst_i;
  logic [5:0]  aw_atop_i;
  logic [0:0]  aw_user_i;
  logic        w_valid_i, w_ready_o;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        w_last_i;
  logic [0:0]  w_user_i;
  logic        b_valid_o, b_ready_i;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic [0:0]  b_user_o;
  logic        ar_valid_i, ar_ready_o;
  logic [3:0]  ar_id_i;
  logic [63:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic [0:0]  ar_user_i;
  logic        r_valid_o, r_ready_i;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [0:0]  r_user_o;

`ifdef CVA6_AXI_SRAM_USER_ECHO_EN
  localparam logic EXP_USER = 1'b1;
`else
  localparam logic EXP_USER = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  cva6_axi_sram_slave dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_atop_i(aw_atop_i),
    .aw_user_i(aw_user_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i), .w_user_i(w_user_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .b_user_o(b_user_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_user_i(ar_user_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_user_o(r_user_o)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic        rd_user [16];
  logic [3:0]  rd_id;
  int          rd_n;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_id;

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [5:0] atop, input logic [63:0] data0,
                          input logic [63:0] inc, input logic [7:0] strb, input bit bad_last);
    int n;
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = 3'd3;
    aw_burst_i = burst; aw_atop_i = atop; aw_user_i = 1'b0; aw_valid_i = 1'b1;
    n = 0;
    while (!aw_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL aw_timeout addr %h", addr); end
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data_i = data0 + 64'(i) * inc; w_strb_i = strb;
      w_last_i = bad_last ? 1'b0 : (i == int'(len)); w_valid_i = 1'b1;
      n = 0;
      while (!w_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
      if (n >= 50) begin checks++; errors++; $display("FAIL w_timeout beat %0d", i); end
      @(posedge clk_i); #1;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    b_ready_i = 1'b1;
    n = 0;
    while (!b_valid_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL b_timeout addr %h", addr); end
    wr_resp = b_resp_o; wr_id = b_id_o;
    @(posedge clk_i); #1;
    b_ready_i = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id, input logic user,
                         input bit toggle);
    int n;
    bit done;
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_size_i = size;
    ar_burst_i = burst; ar_user_i = user; ar_valid_i = 1'b1;
    n = 0;
    while (!ar_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL ar_timeout addr %h", addr); end
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    checks++;
    if (r_valid_o !== 1'b1) begin
      errors++; $display("FAIL r_first_latency got %b exp 1", r_valid_o);
    end
    rd_n = 0; done = 1'b0; n = 0;
    while (!done && n < 100) begin
      r_ready_i = toggle ? n[0] : 1'b1;
      if (r_valid_o && r_ready_i) begin
        if (rd_n == 0) rd_id = r_id_o;
        if (rd_n < 16) begin
          rd_data[rd_n] = r_data_o; rd_resp[rd_n] = r_resp_o;
          rd_last[rd_n] = r_last_o; rd_user[rd_n] = r_user_o;
        end
        rd_n++;
        if (r_last_o) done = 1'b1;
      end
      @(posedge clk_i); #1;
      n++;
    end
    r_ready_i = 1'b0;
    if (!done) begin checks++; errors++; $display("FAIL r_timeout addr %h beats %0d", addr, rd_n); end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
    aw_atop_i = 0; aw_user_i = 0; w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0;
    w_user_i = 0; b_ready_i = 0; ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0;
    ar_size_i = 0; ar_burst_i = 0; ar_user_i = 0; r_ready_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake got %b exp 000000",
               {aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o});
    end
    checks++;
    if (r_data_o !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", r_data_o); end
    checks++;
    if ({b_id_o, b_resp_o, b_user_o, r_id_o, r_resp_o, r_user_o} !== 14'h0) begin
      errors++;
      $display("FAIL reset_payload got %h exp 0", {b_id_o, b_resp_o, b_user_o, r_id_o, r_resp_o, r_user_o});
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if ({aw_ready_o, ar_ready_o} !== 2'b11) begin
      errors++; $display("FAIL idle_ready got %b exp 11", {aw_ready_o, ar_ready_o});
    end
  endtask

  task automatic test_single();
    do_write(64'h8000_0000, 8'd7, 2'd1, 4'd0, 6'd0, 64'h0, 64'h0, 8'hFF, 1'b0);
    checks++;
    if (wr_resp !== 2'b00) begin errors++; $display("FAIL clear_bresp got %b exp 00", wr_resp); end
    do_write(64'h8000_0008, 8'd0, 2'd1, 4'd0, 6'd0, 64'hA5A5, 64'h0, 8'hFF, 1'b0);
    do_write(64'h8000_0000, 8'd0, 2'd1, 4'd5, 6'd0, 64'h1122334455667788, 64'h0, 8'h0F, 1'b0);
    checks++;
    if (wr_resp !== 2'b00) begin errors++; $display("FAIL single_bresp got %b exp 00", wr_resp); end
    checks++;
    if (wr_id !== 4'd5) begin errors++; $display("FAIL single_bid got %h exp 5", wr_id); end
    do_read(64'h8000_0000, 8'd0, 2'd1, 3'd3, 4'd3, 1'b0, 1'b0);
    checks++;
    if (rd_n !== 1) begin errors++; $display("FAIL single_beats got %0d exp 1", rd_n); end
    checks++;
    if (rd_data[0] !== 64'h0000000055667788) begin
      errors++; $display("FAIL single_rdata got %h exp 0000000055667788", rd_data[0]);
    end
    checks++;
    if ({rd_last[0], rd_resp[0], rd_id} !== {1'b1, 2'b00, 4'd3}) begin
      errors++; $display("FAIL single_rmeta got %h exp %h", {rd_last[0], rd_resp[0], rd_id}, {1'b1, 2'b00, 4'd3});
    end
  endtask

  task automatic test_incr_toggle();
    do_write(64'h8000_0010, 8'd3, 2'd1, 4'd1, 6'd0, 64'h0, 64'h1, 8'hFF, 1'b0);
    checks++;
    if (wr_resp !== 2'b00) begin errors++; $display("FAIL incr_bresp got %b exp 00", wr_resp); end
    do_read(64'h8000_0010, 8'd3, 2'd1, 3'd3, 4'd2, 1'b0, 1'b1);
    checks++;
    if (rd_n !== 4) begin errors++; $display("FAIL incr_beats got %0d exp 4", rd_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 64'(i)) begin
        errors++; $display("FAIL incr_rdata beat %0d got %h exp %h", i, rd_data[i], 64'(i));
      end
      checks++;
      if (rd_last[i] !== (i == 3)) begin
        errors++; $display("FAIL incr_rlast beat %0d got %b exp %b", i, rd_last[i], (i == 3));
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp [4];
    exp[0] = 64'h1; exp[1] = 64'h55667788; exp[2] = 64'hA5A5; exp[3] = 64'h0;
    do_read(64'h8000_0018, 8'd3, 2'd2, 3'd3, 4'd4, 1'b0, 1'b0);
    checks++;
    if (rd_n !== 4) begin errors++; $display("FAIL wrap_beats got %0d exp 4", rd_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_data[i], rd_resp[i]} !== {exp[i], 2'b00}) begin
        errors++; $display("FAIL wrap_rdata beat %0d got %h/%b exp %h/00", i, rd_data[i], rd_resp[i], exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    do_read(64'h7FFF_FFF8, 8'd1, 2'd1, 3'd3, 4'd7, 1'b0, 1'b0);
    checks++;
    if (rd_n !== 2) begin errors++; $display("FAIL oob_beats got %0d exp 2", rd_n); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rd_data[i], rd_resp[i], rd_last[i]} !== {64'h0, 2'b10, (i == 1)}) begin
        errors++; $display("FAIL oob_rbeat %0d got %h/%b/%b exp 0/10/%b", i, rd_data[i], rd_resp[i], rd_last[i], (i == 1));
      end
    end
    do_write(64'h8000_0000, 8'd0, 2'd1, 4'd2, 6'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'hFF, 1'b0);
    checks++;
    if (wr_resp !== 2'b10) begin errors++; $display("FAIL atop_bresp got %b exp 10", wr_resp); end
    do_write(64'h8000_2000, 8'd0, 2'd1, 4'd2, 6'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'hFF, 1'b0);
    checks++;
    if (wr_resp !== 2'b10) begin errors++; $display("FAIL top_oob_bresp got %b exp 10", wr_resp); end
    do_write(64'h8000_1FF8, 8'd0, 2'd1, 4'd2, 6'h0, 64'hCAFE, 64'h0, 8'hFF, 1'b0);
    checks++;
    if (wr_resp !== 2'b00) begin errors++; $display("FAIL last_word_bresp got %b exp 00", wr_resp); end
    do_read(64'h8000_1FF8, 8'd0, 2'd1, 3'd3, 4'd0, 1'b0, 1'b0);
    checks++;
    if (rd_data[0] !== 64'hCAFE) begin errors++; $display("FAIL last_word_rdata got %h exp cafe", rd_data[0]); end
    do_read(64'h8000_0000, 8'd0, 2'd1, 3'd3, 4'd0, 1'b0, 1'b0);
    checks++;
    if (rd_data[0] !== 64'h0000000055667788) begin
      errors++; $display("FAIL err_write_dropped got %h exp 0000000055667788", rd_data[0]);
    end
    do_read(64'h8000_0000, 8'd2, 2'd2, 3'd3, 4'd0, 1'b0, 1'b0);
    checks++;
    if ({rd_n, rd_resp[0], rd_data[0]} !== {32'd3, 2'b10, 64'h0}) begin
      errors++; $display("FAIL wrap_len_err got %0d/%b/%h exp 3/10/0", rd_n, rd_resp[0], rd_data[0]);
    end
    do_read(64'h8000_0000, 8'd0, 2'd1, 3'd4, 4'd0, 1'b0, 1'b0);
    checks++;
    if (rd_resp[0] !== 2'b10) begin errors++; $display("FAIL size_err got %b exp 10", rd_resp[0]); end
    do_write(64'h8000_0040, 8'd0, 2'd1, 4'd9, 6'h0, 64'hAB, 64'h0, 8'hFF, 1'b1);
    checks++;
    if ({wr_resp, wr_id} !== {2'b10, 4'd9}) begin
      errors++; $display("FAIL wlast_mismatch got %b/%h exp 10/9", wr_resp, wr_id);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int beats;
    ar_id_i = 4'd1; ar_addr_i = 64'h8000_0000; ar_len_i = 8'd7; ar_size_i = 3'd3;
    ar_burst_i = 2'd1; ar_user_i = 1'b0; ar_valid_i = 1'b1;
    n = 0;
    while (!ar_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    r_ready_i = 1'b1;
    beats = 0; n = 0;
    while (beats < 2 && n < 50) begin
      if (r_valid_o) beats++;
      @(posedge clk_i); #1;
      n++;
    end
    checks++;
    if ({r_valid_o, r_last_o} !== 2'b10) begin
      errors++; $display("FAIL mid_burst_beat2 got %b exp 10", {r_valid_o, r_last_o});
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({r_valid_o, ar_ready_o, r_data_o} !== 66'h0) begin
      errors++; $display("FAIL async_reset got %b/%b/%h exp 0/0/0", r_valid_o, ar_ready_o, r_data_o);
    end
    r_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if ({ar_ready_o, r_valid_o} !== 2'b10) begin
      errors++; $display("FAIL post_reset_idle got %b exp 10", {ar_ready_o, r_valid_o});
    end
    do_read(64'h8000_0008, 8'd0, 2'd1, 3'd3, 4'd6, 1'b0, 1'b0);
    checks++;
    if ({rd_n, rd_data[0]} !== {32'd1, 64'hA5A5}) begin
      errors++; $display("FAIL post_reset_read got %0d/%h exp 1/a5a5", rd_n, rd_data[0]);
    end
  endtask

  task automatic test_user();
    do_read(64'h8000_0000, 8'd1, 2'd1, 3'd3, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_user[i] !== EXP_USER) begin
        errors++; $display("FAIL r_user beat %0d got %b exp %b", i, rd_user[i], EXP_USER);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_toggle();
    test_wrap();
    test_errors();
    test_reset_mid();
    test_user();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
